// File: rtl/div_by_3_encoder.sv
// Serial framer: shifts an N-bit word out MSB-first, then appends a 2-bit
// check code so that the whole (N+2)-bit frame is a multiple of three.
module div_by_3_encoder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:N-1] din,
    output logic         ser_out,
    output logic         ser_valid,
    input  logic         ser_ready,
    output logic         ser_last,
    output logic         busy
);

    localparam int CW = $clog2(N + 3);
    localparam logic [CW-1:0] LAST_DATA  = CW'(N - 1);
    localparam logic [CW-1:0] FIRST_CHK  = CW'(N);
    localparam logic [CW-1:0] SECOND_CHK = CW'(N + 1);
    localparam logic [CW-1:0] FRAME_END  = CW'(N + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state_reg;
    logic [N-1:0]    shift_reg;
    logic [N-1:0]    shift_next;
    logic [N-1:0]    din_word;
    logic [CW-1:0]   count_reg;
    logic [1:0]      rem_reg;
    logic [1:0]      rem_next;
    logic [1:0]      check_next;
    logic [1:0]      check_cur;
    logic            handshake;

    // din is declared MSB-at-index-0; flip it into a conventional vector.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_din_flip
            assign din_word[N-1-gi] = din[gi];
        end
    endgenerate

    // Running remainder of the bits sent so far; 3 is unreachable and acts as 0.
    function automatic logic [1:0] rem_step(input logic [1:0] r, input logic b);
        case (r)
            2'd1:    rem_step = b ? 2'd0 : 2'd2;
            2'd2:    rem_step = b ? 2'd2 : 2'd1;
            default: rem_step = b ? 2'd1 : 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] check_code(input logic [1:0] r);
        case (r)
            2'd1:    check_code = 2'b10;
            2'd2:    check_code = 2'b01;
            default: check_code = 2'b00;
        endcase
    endfunction

    always_comb begin
        handshake  = ser_valid & ser_ready;
        shift_next = shift_reg << 1;
        rem_next   = rem_step(rem_reg, ser_out);
        check_next = check_code(rem_next);
        check_cur  = check_code(rem_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            rem_reg   <= 2'd0;
            in_ready  <= 1'b1;
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= DATA;
                        shift_reg <= din_word;
                        count_reg <= '0;
                        rem_reg   <= 2'd0;
                        in_ready  <= 1'b0;
                        ser_valid <= 1'b1;
                        ser_out   <= din_word[N-1];
                        ser_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DATA: begin
                    if (handshake) begin
                        rem_reg   <= rem_next;
                        shift_reg <= shift_next;
                        count_reg <= count_reg + CW'(1);
                        if (count_reg == LAST_DATA) begin
                            // The code depends on the remainder including this bit.
                            state_reg <= CHECK;
                            ser_out   <= check_next[1];
                        end else begin
                            ser_out   <= shift_next[N-1];
                        end
                    end
                end
                CHECK: begin
                    if (handshake) begin
                        if (count_reg == FIRST_CHK) begin
                            ser_out   <= check_cur[0];
                            ser_last  <= 1'b1;
                            count_reg <= SECOND_CHK;
                        end else begin
                            state_reg <= IDLE;
                            count_reg <= FRAME_END;
                            in_ready  <= 1'b1;
                            ser_valid <= 1'b0;
                            ser_out   <= 1'b0;
                            ser_last  <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    ser_valid <= 1'b0;
                    ser_out   <= 1'b0;
                    ser_last  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_by_3_encoder.sv
// Randomised bench for div_by_3_encoder: frames are predicted arithmetically
// (data*4 + check, check making the sum divisible by 3) and compared bit by bit.
module tb_div_by_3_encoder;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] din;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_ready;
    logic         ser_last;
    logic         busy;

    int n_checks;
    int n_pass;

    div_by_3_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive_word(input logic [N-1:0] word);
        for (int i = 0; i < N; i++) din[i] = word[N-1-i];
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(ser_valid), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_last"},  32'(ser_last), 32'd0);
    endtask

    // Sends one frame; called at a negedge with the encoder idle.
    // ready_pct: chance ser_ready is high; stall_at/stall_len: forced stall after
    // that many bits; abort_at: reset after that many bits (-1 = never);
    // poke: spray ignored in_valid pulses; exp_cycles: expected valid cycles (-1 = skip).
    task automatic send_frame(input logic [N-1:0] word, input int ready_pct,
                              input int stall_at, input int stall_len,
                              input int abort_at, input bit poke, input int exp_cycles);
        int unsigned frame;
        int unsigned got_val;
        int idx;
        int cycles;
        int stalls;
        bit rdy;
        bit prev_stalled;
        logic prev_out;
        logic prev_last;
        logic exp_bit;

        frame   = 32'(word) * 4 + ((3 - (32'(word) % 3)) % 3);
        got_val = 0;
        idx = 0; cycles = 0; stalls = 0; prev_stalled = 0;
        prev_out = 1'b0; prev_last = 1'b0;

        check("load_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        drive_word(word);
        @(negedge clk);
        in_valid = 1'b0;

        while (idx < N + 2 && cycles < 200) begin
            check("valid", 32'(ser_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("in_ready_low", 32'(in_ready), 32'd0);
            if (prev_stalled) begin
                check("stall_out", 32'(ser_out), 32'(prev_out));
                check("stall_last", 32'(ser_last), 32'(prev_last));
            end
            if (idx == abort_at) begin
                rst = 1'b1;
                ser_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_idle("abort");
                check("abort_out", 32'(ser_out), 32'd0);
                return;
            end
            if (idx == stall_at && stalls < stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(0, 99) < ready_pct);
            end
            if (rdy) begin
                exp_bit = frame[N+1-idx];
                check("bit", 32'(ser_out), 32'(exp_bit));
                check("last", 32'(ser_last), 32'(idx == N + 1));
                got_val = (got_val << 1) | 32'(ser_out);
                idx++;
            end
            prev_stalled = !rdy;
            prev_out  = ser_out;
            prev_last = ser_last;
            cycles++;
            in_valid = poke && ($urandom_range(0, 3) == 0);
            if (in_valid) drive_word(N'($urandom));
            ser_ready = rdy;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        check("timeout", 32'(idx), 32'(N + 2));
        check("frame_mod3", got_val % 3, 32'd0);
        check("frame_val", got_val, frame);
        if (exp_cycles >= 0) check("valid_cycles", 32'(cycles), 32'(exp_cycles));
        check_idle("end");
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        ser_ready = 1'b0;
        din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");
        check("reset_out", 32'(ser_out), 32'd0);

        send_frame(8'h06, 100, -1, 0, -1, 1'b0, 10);
        send_frame(8'h07, 100, -1, 0, -1, 1'b0, 10);
        send_frame(8'h02, 100, -1, 0, -1, 1'b0, 10);
        send_frame(8'hFF, 100, -1, 0, -1, 1'b0, 10);
        send_frame(8'hA5, 100,  4, 3, -1, 1'b0, 13);
        send_frame(8'hFF, 100, -1, 0,  5, 1'b0, -1);
        send_frame(8'h03, 100, -1, 0, -1, 1'b0, 10);
        send_frame(8'h2C, 100, -1, 0, -1, 1'b1, 10);

        for (int v = 0; v < 256; v++)
            send_frame(N'(v), 60, -1, 0, -1, 1'b1, -1);
        for (int k = 0; k < 60; k++)
            send_frame(N'($urandom), 50, $urandom_range(0, 9), $urandom_range(0, 4),
                       ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : -1, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_by_3_encoder.md
Name: div_by_3_encoder

Overview:
- Serial transmitter that produces frames the divisible-by-3 detector accepts.
- Takes an N-bit parallel word and shifts it out MSB-first, followed by a 2-bit check code C.
- C is chosen so the (N+2)-bit frame value (data*4 + C) is divisible by 3.
- Sits upstream of the detector, which is instantiated with width N+2.

Parameters:
N, 8, data word width in bits (2..14); frame length is N+2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  din is presented for loading
in_ready  output  1  encoder can accept a word this cycle
din  input  [0:N-1]  data word; din[0] is the MSB and is sent first
ser_out  output  1  current serial bit
ser_valid  output  1  ser_out holds a valid frame bit
ser_ready  input  1  sink accepts ser_out this cycle
ser_last  output  1  ser_out is the final (check) bit of the frame
busy  output  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset: rst is sampled on the rising edge of clk. It forces:
  - state=IDLE, shift register=0, count=0, rem=0;
  - outputs in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
- Reset mid-frame aborts the frame. Untransmitted bits are discarded and no partial check code is sent.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, load din into the shift register, clear count and rem, go to DATA. When in_valid=0, stay in IDLE.
  - DATA: ser_valid=1 and ser_out = the current MSB of the shift register.
    - On each handshake (ser_valid & ser_ready): rem <= (2*rem + ser_out) mod 3, with the mapping 0->{0,1}, 1->{2,0}, 2->{1,2}. Then shift left and increment count.
    - After the handshake of the N-th data bit, go to CHECK.
  - CHECK: sends C = (3 - rem) mod 3 as 2 bits, MSB first. rem=0 gives C=00, rem=1 gives C=10, rem=2 gives C=01.
    - C is computed from the final rem after the last data bit is included.
    - ser_last=1 during the second check bit only.
    - On the handshake of that bit, go to IDLE.
- Handshake rules:
  - A bit is transferred only on a cycle where ser_valid=1 and ser_ready=1.
  - While ser_ready=0, ser_out, ser_last and the state hold stable.
- Input handshake:
  - in_ready=1 only in IDLE.
  - in_valid in any other state is ignored and din is not sampled.
  - There is one IDLE cycle between frames, so minimum frame spacing is N+3 cycles.
- Latency: a word is accepted on cycle T, and its first bit is valid on cycle T+1. With ser_ready held high, ser_last is asserted on cycle T+N+2.
- Width rules:
  - count is wide enough for N+2 and saturates at the frame end.
  - rem is 2 bits; the value 3 is unreachable and, if ever present, is treated as 0.
- Frame invariant: the (N+2) bits emitted per frame, read MSB-first, always form a multiple of 3.
- Back-to-back loading while busy is not supported.

Test Plan:
- Reset, then din=8'h06 (6, rem 0), ser_ready=1 -> stream 0000011000, ser_last on the 10th bit, ser_valid high for 10 cycles.
- din=8'h07 (7, rem 1) -> stream 0000011110 (value 30), C=10.
- din=8'h02 and din=8'hFF -> C=01 (value 9) and C=00 (value 1020) respectively.
- din=8'hA5, ser_ready low for 3 cycles after the 4th bit -> ser_out holds its value across the stall, stream is 1010010100 (value 660), total 13 valid cycles.
- rst asserted after the 5th bit of 8'hFF -> next cycle ser_valid=0, in_ready=1, busy=0. A new word 8'h03 then produces a clean 0000001100.
- in_valid pulsed with 8'h55 mid-frame -> ignored; the current frame completes unchanged and in_ready stays low until IDLE.
- Loopback into the detector (N=10) over all 256 values -> detector reports divisible at the end of every frame.
